// File: rtl/abs_pkg.sv
// Shared constants and result type for the registered absolute-value unit.
// Build option: ABSOLUTE_VALUE_SAT_EN selects MIN_INT saturation (see abs_core).
package abs_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Most negative operand and largest positive magnitude at the default width.
    localparam logic [DEFAULT_WIDTH-1:0] MIN_INT = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};
    localparam logic [DEFAULT_WIDTH-1:0] MAX_POS = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] magnitude;
        logic                     neg;
        logic                     ovf;
    } abs_result_t;

endpackage

// File: rtl/abs_core.sv
// Combinational magnitude/sign/overflow for a two's-complement operand.
// ABSOLUTE_VALUE_SAT_EN defined: MIN_INT clamps to MAX_POS; undefined: it wraps.
module abs_core
    import abs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] magnitude,
    output logic             neg,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ABSOLUTE_VALUE_SAT_EN
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    logic [WIDTH-1:0] negated;

    always_comb begin
        negated   = (~in) + {{(WIDTH-1){1'b0}}, 1'b1};
        neg       = in[WIDTH-1];
        ovf       = (in == MIN_VAL);
        magnitude = neg ? negated : in;
`ifdef ABSOLUTE_VALUE_SAT_EN
        if (ovf) begin
            magnitude = MAX_VAL;
        end
`endif
    end

endmodule

// File: rtl/absolute_value.sv
// Registered signed absolute value: one-cycle latency, one operand per cycle.
// Build option: ABSOLUTE_VALUE_SAT_EN (MIN_INT saturates instead of wrapping).
module absolute_value
    import abs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             neg,
    output logic             ovf
);

    // Valid semantics: no ready. An edge with in_valid=1 captures the operand and
    // raises out_valid for exactly the next cycle; with in_valid=0 out_valid drops
    // and out/neg/ovf keep the last captured result.
    logic [WIDTH-1:0] core_mag;
    logic             core_neg;
    logic             core_ovf;

    abs_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .in       (in),
        .magnitude(core_mag),
        .neg      (core_neg),
        .ovf      (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= core_mag;
                neg <= core_neg;
                ovf <= core_ovf;
            end
        end
    end

endmodule

// File: tb/tb_absolute_value.sv
// Self-checking bench for absolute_value against an integer-arithmetic reference.
// Compile with +define+ABSOLUTE_VALUE_SAT_EN to check the saturating build.
module tb_absolute_value;
    import abs_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in;
    logic         out_valid;
    logic [W-1:0] out;
    logic         neg;
    logic         ovf;

    int vectors;
    int miscompares;

    // Expected {neg, ovf, magnitude} for operands in flight.
    logic [W+1:0] exp_q[$];

    absolute_value #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (in),
        .out_valid(out_valid),
        .out      (out),
        .neg      (neg),
        .ovf      (ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic abs_result_t model(input logic [W-1:0] x);
        abs_result_t r;
        int v;
        int m;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        r.neg = (v < 0);
        r.ovf = (m == (1 << (W - 1)));
        if (r.ovf) begin
`ifdef ABSOLUTE_VALUE_SAT_EN
            m = (1 << (W - 1)) - 1;
`else
            m = 1 << (W - 1);
`endif
        end
        r.magnitude = m[W-1:0];
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] x);
        rst      = r;
        in_valid = v;
        in       = x;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, 16'hFFFB);
            vectors++;
            if ({out_valid, neg, ovf, out} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
                miscompares++;
                $display("FAIL reset[%0d]: got valid=%b neg=%b ovf=%b out=%h, want 0 0 0 0000",
                         i, out_valid, neg, ovf, out);
            end
        end
    endtask

    task automatic test_positive;
        logic [W-1:0] ops[2];
        abs_result_t e;
        ops[0] = 16'd1234;
        ops[1] = 16'd0;
        for (int i = 0; i < 2; i++) begin
            e = model(ops[i]);
            drive_cycle(1'b0, 1'b1, ops[i]);
            vectors++;
            if ({out_valid, neg, ovf, out} !== {1'b1, e.neg, e.ovf, e.magnitude}) begin
                miscompares++;
                $display("FAIL positive in=%h: got valid=%b neg=%b ovf=%b out=%h, want 1 %b %b %h",
                         ops[i], out_valid, neg, ovf, out, e.neg, e.ovf, e.magnitude);
            end
        end
    endtask

    task automatic test_negative;
        logic [W-1:0] ops[2];
        abs_result_t e;
        ops[0] = 16'hFFFF;
        ops[1] = 16'h8001;
        for (int i = 0; i < 2; i++) begin
            e = model(ops[i]);
            drive_cycle(1'b0, 1'b1, ops[i]);
            vectors++;
            if ({out_valid, neg, ovf, out} !== {1'b1, e.neg, e.ovf, e.magnitude}) begin
                miscompares++;
                $display("FAIL negative in=%h: got valid=%b neg=%b ovf=%b out=%h, want 1 %b %b %h",
                         ops[i], out_valid, neg, ovf, out, e.neg, e.ovf, e.magnitude);
            end
        end
    endtask

    task automatic test_min_int;
        logic [W-1:0] want_out;
`ifdef ABSOLUTE_VALUE_SAT_EN
        want_out = MAX_POS;
`else
        want_out = MIN_INT;
`endif
        drive_cycle(1'b0, 1'b1, MIN_INT);
        vectors++;
        if ({out_valid, neg, ovf, out} !== {1'b1, 1'b1, 1'b1, want_out}) begin
            miscompares++;
            $display("FAIL min_int: got valid=%b neg=%b ovf=%b out=%h, want 1 1 1 %h",
                     out_valid, neg, ovf, out, want_out);
        end
    endtask

    task automatic test_back_to_back;
        abs_result_t e;
        logic [W+1:0] got;
        logic [W+1:0] want;
        logic [W+1:0] last;
        logic [W-1:0] x;
        last = '0;
        for (int i = 0; i < 10; i++) begin
            x = W'($urandom_range(0, 65535));
            e = model(x);
            exp_q.push_back({e.neg, e.ovf, e.magnitude});
            drive_cycle(1'b0, 1'b1, x);
            want = exp_q.pop_front();
            last = want;
            got = {neg, ovf, out};
            vectors++;
            if (!out_valid || got !== want) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] in=%h: got valid=%b {neg,ovf,out}=%h, want 1 %h",
                         i, x, out_valid, got, want);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, W'($urandom_range(0, 65535)));
            got = {neg, ovf, out};
            vectors++;
            if (out_valid !== 1'b0 || got !== last) begin
                miscompares++;
                $display("FAIL hold[%0d]: got valid=%b {neg,ovf,out}=%h, want 0 %h",
                         i, out_valid, got, last);
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        // A valid -3 is captured first; -7 is then in flight at the edge where rst rises.
        drive_cycle(1'b0, 1'b1, 16'hFFFD);
        vectors++;
        if ({out_valid, out} !== {1'b1, 16'd3}) begin
            miscompares++;
            $display("FAIL mid_reset_prime: got valid=%b out=%h, want 1 0003", out_valid, out);
        end
        drive_cycle(1'b1, 1'b1, 16'hFFF9);
        vectors++;
        if ({out_valid, neg, ovf, out} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b neg=%b ovf=%b out=%h, want 0 0 0 0000",
                     out_valid, neg, ovf, out);
        end
        drive_cycle(1'b0, 1'b0, 16'h0000);
        vectors++;
        if ({out_valid, out} !== {1'b0, {W{1'b0}}}) begin
            miscompares++;
            $display("FAIL mid_reset_after: got valid=%b out=%h, want 0 0000", out_valid, out);
        end
    endtask

    task automatic test_random_stream;
        abs_result_t e;
        logic [W+1:0] held;
        logic [W-1:0] x;
        logic v;
        held = {neg, ovf, out};
        held = '0;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       x = MIN_INT;
                1:       x = '0;
                2:       x = MAX_POS;
                default: x = W'($urandom_range(0, 65535));
            endcase
            if (v) begin
                e = model(x);
                held = {e.neg, e.ovf, e.magnitude};
            end
            drive_cycle(1'b0, v, x);
            vectors++;
            if (out_valid !== v || {neg, ovf, out} !== held) begin
                miscompares++;
                $display("FAIL random[%0d] v=%b in=%h: got valid=%b {neg,ovf,out}=%h, want %b %h",
                         i, v, x, out_valid, {neg, ovf, out}, v, held);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in          = '0;
        @(negedge clk);
        test_reset();
        // The reset wins over in_valid, so the outputs start from zero here.
        test_positive();
        test_negative();
        test_min_int();
        test_back_to_back();
        test_reset_mid_stream();
        test_random_stream();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
